// File: rtl/ps2_host_tx_if.sv
// Command handshake between the game control FSM (master) and the
// PS/2 host transmitter (slave): byte request plus done/error feedback.
interface ps2_host_tx_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output cmd_data,
        output cmd_valid,
        input  cmd_ready,
        input  busy,
        input  tx_done,
        input  tx_error
    );

    modport slave (
        input  cmd_data,
        input  cmd_valid,
        output cmd_ready,
        output busy,
        output tx_done,
        output tx_error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Inhibits the bus, issues a request-to-send,
// then shifts one command byte (LSB first, odd parity, stop bit) on the
// device-generated clock and checks the device ACK. Lines are only ever
// pulled low or released; the top level owns the tristate buffers.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int CNT_W          = 20
) (
    input  logic         clk,
    input  logic         reset,
    ps2_host_tx_if.slave cmd,
    input  logic         ps2_clk_in,
    input  logic         ps2_dat_in,
    output logic         ps2_clk_pull,
    output logic         ps2_dat_pull
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INHIBIT   = 3'd1;
    localparam logic [2:0] REQ       = 3'd2;
    localparam logic [2:0] SHIFT     = 3'd3;
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] ACK       = 3'd5;
    localparam logic [2:0] WAIT_IDLE = 3'd6;

    // The single REQ cycle (clock and data both pulled) is the last cycle of
    // the inhibit window, so INHIBIT itself lasts INHIBIT_CYCLES-1 cycles.
    localparam int               INHIBIT_WAIT = (INHIBIT_CYCLES > 2) ? INHIBIT_CYCLES - 2 : 0;
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_WAIT);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [8:0]       shift;
    logic [3:0]       bit_idx;
    logic [1:0]       clk_sync;
    logic [1:0]       dat_sync;
    logic             clk_prev;
    logic             done_q;
    logic             error_q;
    logic             fe;
    logic             accept;
    logic             timed_out;

    assign cmd.cmd_ready = (state == IDLE);
    assign cmd.busy      = (state != IDLE);
    assign cmd.tx_done   = done_q;
    assign cmd.tx_error  = error_q;

    assign accept    = cmd.cmd_valid && (state == IDLE);
    assign fe        = clk_prev && !clk_sync[1];
    assign timed_out = (state != IDLE) && (state != INHIBIT) && (cnt == TIMEOUT_LAST);

    // Two-flop synchronisers for the asynchronous PS/2 lines plus the delayed
    // clock sample used for falling-edge detection; idle bus level is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_dat_in};
            clk_prev <= clk_sync[1];
        end
    end

    // Transfer sequencer: inhibit, request, shift, stop, ACK check, bus-idle
    // wait, with the shared counter doubling as inhibit timer and timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            shift        <= '0;
            bit_idx      <= '0;
            ps2_clk_pull <= 1'b0;
            ps2_dat_pull <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (timed_out) begin
                ps2_clk_pull <= 1'b0;
                ps2_dat_pull <= 1'b0;
                error_q      <= 1'b1;
                state        <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            shift        <= {~^cmd.cmd_data, cmd.cmd_data};
                            cnt          <= '0;
                            bit_idx      <= '0;
                            ps2_clk_pull <= 1'b1;
                            ps2_dat_pull <= 1'b0;
                            state        <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (cnt >= INHIBIT_LAST) begin
                            ps2_dat_pull <= 1'b1;
                            cnt          <= '0;
                            state        <= REQ;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    REQ: begin
                        ps2_clk_pull <= 1'b0;
                        cnt          <= '0;
                        bit_idx      <= '0;
                        state        <= SHIFT;
                    end
                    SHIFT: begin
                        cnt <= cnt + CNT_ONE;
                        if (fe) begin
                            ps2_dat_pull <= ~shift[0];
                            shift        <= {1'b0, shift[8:1]};
                            bit_idx      <= bit_idx + 4'd1;
                            if (bit_idx == 4'd8) begin
                                state <= STOP;
                            end
                        end
                    end
                    STOP: begin
                        cnt <= cnt + CNT_ONE;
                        if (fe) begin
                            ps2_dat_pull <= 1'b0;
                            state        <= ACK;
                        end
                    end
                    ACK: begin
                        cnt <= cnt + CNT_ONE;
                        if (fe) begin
                            if (!dat_sync[1]) begin
                                state <= WAIT_IDLE;
                            end else begin
                                ps2_clk_pull <= 1'b0;
                                ps2_dat_pull <= 1'b0;
                                error_q      <= 1'b1;
                                state        <= IDLE;
                            end
                        end
                    end
                    WAIT_IDLE: begin
                        cnt <= cnt + CNT_ONE;
                        if (clk_sync[1] && dat_sync[1]) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                    default: begin
                        ps2_clk_pull <= 1'b0;
                        ps2_dat_pull <= 1'b0;
                        state        <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural keyboard model clocks frames out of
// the host and compares the bits seen on its rising edges, plus the
// done/error pulses and line pulls, against an arithmetic frame model.
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int TMO = 3000;

    logic clk = 1'b0;
    logic reset;
    logic ps2_clk_pull;
    logic ps2_dat_pull;
    logic dev_clk_low;
    logic dev_dat_low;
    logic clk_line;
    logic dat_line;

    int checks = 0;
    int errors = 0;

    int done_cnt     = 0;
    int err_cnt      = 0;
    int clk_pull_cnt = 0;
    int overlap_cnt  = 0;
    int excl_bad     = 0;
    int done_busy    = 0;

    ps2_host_tx_if cmd_if ();

    assign clk_line = ~(ps2_clk_pull | dev_clk_low);
    assign dat_line = ~(ps2_dat_pull | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd(cmd_if),
        .ps2_clk_in(clk_line),
        .ps2_dat_in(dat_line),
        .ps2_clk_pull(ps2_clk_pull),
        .ps2_dat_pull(ps2_dat_pull)
    );

    // 100 MHz-style bench clock; only cycle counts matter here.
    always #5 clk = ~clk;

    // Running tallies of pulses and pull activity, sampled mid-cycle.
    always @(negedge clk) begin
        if (cmd_if.tx_done) done_cnt++;
        if (cmd_if.tx_error) err_cnt++;
        if (ps2_clk_pull) clk_pull_cnt++;
        if (ps2_clk_pull && ps2_dat_pull) overlap_cnt++;
        if (cmd_if.tx_done && cmd_if.tx_error) excl_bad++;
        if (cmd_if.tx_done && cmd_if.busy) done_busy++;
    end

    // Expected 11-bit frame as seen on the wire: start 0, data LSB first,
    // parity making the total count of ones odd, stop 1.
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = $countones(b);
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic snap(output int d, output int e, output int c, output int o);
        @(negedge clk);
        #1;
        d = done_cnt;
        e = err_cnt;
        c = clk_pull_cnt;
        o = overlap_cnt;
    endtask

    // Issue one command through the handshake and confirm it was taken.
    task automatic apply_stimulus(input logic [7:0] b, input string tag);
        @(negedge clk);
        check_output({tag, " ready"}, {31'd0, cmd_if.cmd_ready}, 32'd1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_data  = b;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        check_output({tag, " busy"}, {31'd0, cmd_if.busy}, 32'd1);
    endtask

    // Keyboard model: waits for the request-to-send, records the start bit,
    // then generates n_pulses clock pulses sampling data on each rise.
    task automatic device_frame(input int half, input bit ack, input int n_pulses,
                                output logic [10:0] seen, output bit ok);
        int guard;
        seen  = '0;
        ok    = 1'b0;
        guard = 0;
        while (!(clk_line && !dat_line && cmd_if.busy) && guard < 8 * INH) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 8 * INH) return;
        seen[0] = dat_line;
        for (int k = 1; k <= n_pulses; k++) begin
            repeat (half) @(negedge clk);
            if (k == 11 && ack) begin
                dev_dat_low = 1'b1;
                repeat (2) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (half) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k <= 10) seen[k] = dat_line;
        end
        repeat (3) @(negedge clk);
        dev_dat_low = 1'b0;
        ok = 1'b1;
    endtask

    task automatic wait_pulse(output int n);
        n = 0;
        while (!cmd_if.tx_done && !cmd_if.tx_error && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    // A complete acknowledged transfer with all end-of-frame checks.
    task automatic full_transfer(input logic [7:0] b, input int half, input string tag);
        int d0, e0, c0, o0, n;
        logic [10:0] seen;
        bit ok;
        snap(d0, e0, c0, o0);
        apply_stimulus(b, tag);
        device_frame(half, 1'b1, 11, seen, ok);
        check_output({tag, " request"}, {31'd0, ok}, 32'd1);
        check_output({tag, " bits"}, {21'd0, seen}, {21'd0, frame_bits(b)});
        wait_pulse(n);
        check_output({tag, " done"}, {31'd0, cmd_if.tx_done}, 32'd1);
        check_output({tag, " busy fall"}, {31'd0, cmd_if.busy}, 32'd0);
        @(negedge clk);
        #1;
        check_output({tag, " done count"}, done_cnt - d0, 32'd1);
        check_output({tag, " error count"}, err_cnt - e0, 32'd0);
        check_output({tag, " inhibit len"}, clk_pull_cnt - c0, INH);
        check_output({tag, " req overlap"}, overlap_cnt - o0, 32'd1);
        check_output({tag, " released"}, {30'd0, ps2_clk_pull, ps2_dat_pull}, 32'd0);
    endtask

    initial begin
        int d0, e0, c0, o0, n, half;
        logic [10:0] seen;
        logic [7:0] b;
        bit ok;

        reset            = 1'b1;
        dev_clk_low      = 1'b0;
        dev_dat_low      = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_output("reset ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        check_output("reset busy", {31'd0, cmd_if.busy}, 32'd0);
        check_output("reset pulls", {30'd0, ps2_clk_pull, ps2_dat_pull}, 32'd0);
        check_output("reset pulses", {30'd0, cmd_if.tx_done, cmd_if.tx_error}, 32'd0);
        reset = 1'b0;

        // Stray device clock edges while idle must not start anything.
        for (int i = 0; i < 3; i++) begin
            repeat (10) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (10) @(negedge clk);
            dev_clk_low = 1'b0;
        end
        repeat (5) @(negedge clk);
        check_output("idle fe busy", {31'd0, cmd_if.busy}, 32'd0);
        check_output("idle fe pulls", {30'd0, ps2_clk_pull, ps2_dat_pull}, 32'd0);

        full_transfer(8'hED, 25, "ED");
        full_transfer(8'hF4, 20, "F4");
        full_transfer(8'h00, 30, "00");

        // Device never clocks: error exactly TMO cycles after clock release.
        snap(d0, e0, c0, o0);
        apply_stimulus(8'hF4, "timeout");
        n = 0;
        while (ps2_clk_pull && n < 4 * INH) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!cmd_if.tx_error && n < 2 * TMO) begin
            @(negedge clk);
            n++;
        end
        check_output("timeout latency", n, TMO);
        check_output("timeout ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        check_output("timeout pulls", {30'd0, ps2_clk_pull, ps2_dat_pull}, 32'd0);
        @(negedge clk);
        #1;
        check_output("timeout done count", done_cnt - d0, 32'd0);
        check_output("timeout error count", err_cnt - e0, 32'd1);

        // Missing ACK on the 11th falling edge.
        snap(d0, e0, c0, o0);
        apply_stimulus(8'hED, "noack");
        device_frame(22, 1'b0, 11, seen, ok);
        check_output("noack bits", {21'd0, seen}, {21'd0, frame_bits(8'hED)});
        repeat (5) @(negedge clk);
        #1;
        check_output("noack error count", err_cnt - e0, 32'd1);
        check_output("noack done count", done_cnt - d0, 32'd0);
        check_output("noack pulls", {30'd0, ps2_clk_pull, ps2_dat_pull}, 32'd0);
        check_output("noack ready", {31'd0, cmd_if.cmd_ready}, 32'd1);

        // Reset after the 4th data bit, then a clean 0xFF transfer.
        snap(d0, e0, c0, o0);
        apply_stimulus(8'hED, "midreset");
        device_frame(20, 1'b1, 4, seen, ok);
        check_output("midreset partial bits", {27'd0, seen[4:0]}, {27'd0, frame_bits(8'hED) & 11'h01F});
        reset = 1'b1;
        @(negedge clk);
        check_output("midreset pulls", {30'd0, ps2_clk_pull, ps2_dat_pull}, 32'd0);
        check_output("midreset busy", {31'd0, cmd_if.busy}, 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check_output("midreset no pulse", (done_cnt - d0) + (err_cnt - e0), 32'd0);
        full_transfer(8'hFF, 24, "FF");

        // cmd_valid held with 0x11 during a 0xED transfer.
        snap(d0, e0, c0, o0);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_data  = 8'hED;
        @(negedge clk);
        cmd_if.cmd_data = 8'h11;
        check_output("hold busy", {31'd0, cmd_if.busy}, 32'd1);
        device_frame(21, 1'b1, 11, seen, ok);
        check_output("hold first bits", {21'd0, seen}, {21'd0, frame_bits(8'hED)});
        wait_pulse(n);
        check_output("hold first done", {31'd0, cmd_if.tx_done}, 32'd1);
        check_output("hold ready at done", {31'd0, cmd_if.cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        check_output("hold second accept", {31'd0, cmd_if.busy}, 32'd1);
        device_frame(21, 1'b1, 11, seen, ok);
        check_output("hold second bits", {21'd0, seen}, {21'd0, frame_bits(8'h11)});
        wait_pulse(n);
        check_output("hold second done", {31'd0, cmd_if.tx_done}, 32'd1);
        @(negedge clk);
        #1;
        check_output("hold done count", done_cnt - d0, 32'd2);
        check_output("hold error count", err_cnt - e0, 32'd0);

        // Randomised bytes and device clock rates.
        for (int i = 0; i < 4; i++) begin
            b    = 8'($urandom_range(0, 255));
            half = $urandom_range(15, 35);
            $display("[TB] random transfer 0x%02h half=%0d", b, half);
            full_transfer(b, half, "random");
        end

        @(negedge clk);
        #1;
        check_output("pulse exclusivity", excl_bad, 32'd0);
        check_output("done while busy", done_busy, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the shared open-drain PS/2 clock/data lines.
- Sits beside the PS/2 receiver and scan-code decoder. The game control FSM issues commands through a valid/ready handshake and gets a done or error pulse back.
- The block only ever pulls lines low or releases them; top-level tristate buffers perform the actual driving.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles ps2_clk is held low before the request (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: max clk cycles from clock release to ACK before aborting (15 ms at 50 MHz).
- CNT_W, 20: width of the shared cycle counter. Must hold both cycle counts above.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  reset, synchronous, active-high
- cmd_data  in  8  command byte, sampled on handshake
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready
- ps2_clk_in  in  1  raw PS/2 clock line (asynchronous)
- ps2_dat_in  in  1  raw PS/2 data line (asynchronous)
- ps2_clk_pull  out  1  1 = pull clock line low, 0 = release
- ps2_dat_pull  out  1  1 = pull data line low, 0 = release
- busy  out  1  high in every state except IDLE
- tx_done  out  1  one-cycle pulse: byte acknowledged by device
- tx_error  out  1  one-cycle pulse: timeout or missing ACK

Behaviour:
- Reset values: cmd_ready=1, busy=0, ps2_clk_pull=0, ps2_dat_pull=0, tx_done=0, tx_error=0; state IDLE; counters cleared.
- Reset asserted mid-transfer: both lines are released and IDLE is entered on the next clk edge. No done/error pulse is issued.
- Input sync: ps2_clk_in and ps2_dat_in each pass through 2 flops.
- Falling edge (fe): synced clock previous 1, current 0. Visible 3 clk after the line edge.
- Frame: shift register holds {parity, cmd_data[7:0]}, sent LSB first.
  - parity = ~^cmd_data (odd parity).
  - Bit counter is 4 bits.
- State IDLE:
  - cmd_ready=1.
  - On accept: latch byte and parity, clear counter, go INHIBIT.
  - cmd_valid while not IDLE is ignored; the byte is not latched.
- State INHIBIT:
  - ps2_clk_pull=1.
  - After INHIBIT_CYCLES cycles: ps2_dat_pull=1 (start bit 0), clear counter, go REQ.
- State REQ:
  - Hold ps2_dat_pull=1 one cycle with ps2_clk_pull=1, then release the clock (ps2_clk_pull=0).
  - Timeout counter starts. Go SHIFT with bit index 0.
- State SHIFT:
  - On each fe: ps2_dat_pull = ~shift[0], shift right, index+1.
  - Data changes only while the clock is low; the device samples on the rising edge.
  - After the 9th fe (parity placed), go STOP.
- State STOP:
  - On next fe: ps2_dat_pull=0 (stop bit released high), go ACK.
- State ACK:
  - On next fe: sample synced data. 0 → go WAIT_IDLE. 1 → pulse tx_error, go IDLE.
- State WAIT_IDLE:
  - Wait for synced clock=1 and data=1 (device released the bus).
  - Then pulse tx_done and go IDLE. tx_done occurs the same cycle busy falls.
- Timeout:
  - Counter runs from clock release through WAIT_IDLE.
  - On reaching TIMEOUT_CYCLES in any of REQ/SHIFT/STOP/ACK/WAIT_IDLE: release both lines, pulse tx_error, go IDLE.
- tx_done and tx_error are mutually exclusive and last exactly 1 cycle.
- A new command may be accepted the cycle after either pulse.
- Device-held clock before INHIBIT has no effect: the host inhibit overrides it, per protocol.
- Simultaneous fe and timeout on the same cycle: timeout wins.
- Extra fe edges in IDLE are ignored.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and ACKing → ps2_clk_pull high for exactly 5000 cycles. Data bits observed at device rising edges are 0 (start), then 1,0,1,1,0,1,1,1, then parity 1, then stop 1. tx_done pulses once and busy falls.
- Send 0xF4 → data bits 0,0,1,0,1,1,1,1, parity 0. Send 0x00 → parity 1. Both complete with tx_done.
- Device never clocks after release → tx_error exactly TIMEOUT_CYCLES cycles after clock release. Both pulls are 0 and cmd_ready=1 afterwards.
- Device leaves data high on the 11th falling edge (no ACK) → tx_error pulse, no tx_done, lines released.
- Assert reset after the 4th data bit → next cycle both pulls=0, busy=0, no pulse. A following 0xFF transfer completes normally with parity 1.
- Hold cmd_valid high with 0x11 while busy sending 0xED → only 0xED is transmitted. 0x11 is accepted the cycle after tx_done and sent as a second full frame.
